router_pkt_reader: RTL and testbench
====================================

// Module: router_pkt_reader
// PURPOSE
//  Drains one router output FIFO, rebuilding packets: header, payload, parity.
//  Issues pipelined read_enb pulses against FIFO empty, frames bytes with sop/eop,
//  decodes header fields and checks parity. Sits between router_fifo and the
//  destination-port sink.
// PARAMETERS
//  none (8-bit datapath, 6-bit length, 2-bit address fixed by packet format)
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  soft_reset  in   1  per-port soft reset; same cycle FIFO is flushed
//  vld_out     in   1  FIFO not empty (~empty)
//  data_in     in   8  FIFO dataout, valid cycle after read_enb
//  sink_ready  in   1  downstream can take bytes; gates new reads only
//  read_enb    out  1  FIFO read strobe, one byte per high cycle
//  pkt_data    out  8  captured byte
//  pkt_valid   out  1  pkt_data valid, one cycle per byte
//  pkt_sop     out  1  with pkt_valid: header byte
//  pkt_eop     out  1  with pkt_valid: parity byte
//  hdr_addr    out  2  header[1:0], held from header until next header
//  pkt_len     out  6  header[7:2], payload length, held likewise
//  pkt_done    out  1  one-cycle pulse, cycle after eop byte
//  parity_err  out  1  valid with pkt_done: XOR of all bytes != 0
//  pkt_abort   out  1  one-cycle pulse, soft_reset hit a packet in progress
//  busy        out  1  state != IDLE
// BEHAVIOUR
//  Format: header {len[5:0],addr[1:0]}, len payload bytes (0..63), parity byte =
//   XOR(header, payloads). len=0 legal: header then parity only.
//  Reset: all outputs 0, state IDLE, counters and parity accumulator 0.
//  read_enb = in read state && vld_out && sink_ready && bytes left to request;
//   combinational from regs + inputs; never high when vld_out=0.
//  Read latency 1: byte on data_in in cycle N+1 for read_enb in N; registered to
//   pkt_data/pkt_valid in N+2. Reads pipeline back-to-back, one per cycle.
//  FSM:
//   IDLE     -> HDR_REQ immediately (reset value; IDLE only one cycle after DONE)
//   HDR_REQ  : read_enb when allowed; on read -> HDR_WAIT
//   HDR_WAIT : no reads; capture data_in as header, total_left = len+1 -> BODY
//   BODY     : read while req_cnt < len+1; capture each returning byte;
//              last returning byte (parity) gets pkt_eop -> DONE
//   DONE     : pkt_done=1, parity_err from accumulator; clear acc -> IDLE
//  Counters: req_cnt and rcv_cnt 7 bit (max 64), compared to len+1 zero-extended.
//  Parity acc: XOR every captured byte incl header and parity; 0 = pass.
//  vld_out low mid-packet: stall reads, hold state; no timeout here.
//  sink_ready low: no new reads; in-flight byte still presented next cycle.
//  soft_reset (sync, priority below reset): -> IDLE, drop in-flight byte, pkt_valid
//   forced 0 that cycle, pkt_abort=1 if state was HDR_WAIT/BODY/DONE or a read was
//   in flight; hdr_addr/pkt_len hold; no pkt_done.
//  reset mid-packet: everything to reset values, no abort/done pulse.
//  Back-to-back packets: next HDR_REQ read two cycles after DONE.
// TESTING
//  1 Header 8'h0D (len3,addr1), 11,22,33, parity 0D -> 5 bytes, sop on 0D, eop
//    on 0D, hdr_addr=1, pkt_len=3, pkt_done, parity_err=0, read_enb 1+4 cycles.
//  2 Same packet, parity 8'h0C -> pkt_done with parity_err=1.
//  3 Header 8'h02 (len0,addr2), parity 02 -> sop then eop, parity_err=0.
//  4 vld_out low 3 cycles mid-payload of len-5 packet -> read_enb 0 those cycles,
//    bytes unchanged in order, done after all 7 bytes.
//  5 Header 8'hFF (len63), sink_ready toggling every other cycle -> 65 bytes, no
//    read_enb while sink_ready=0, eop on 65th byte.
//  6 soft_reset after 2nd payload of len-3 packet -> pkt_abort, no pkt_done; next
//    packet decodes cleanly with parity_err=0.

Source files
------------

// File: rtl/router_pkt_reader.sv
// router_pkt_reader
//   Drains one router output FIFO and rebuilds packets of the form
//   {header = {len[5:0], addr[1:0]}, len payload bytes, parity byte}.
//   FIFO reads are issued combinationally and pipelined one per cycle.
//   Each returning byte is registered onto pkt_data/pkt_valid, framed with
//   sop/eop, and folded into a running XOR for the parity check.
//
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   soft_reset  in   per-port soft reset, FIFO flushed in the same cycle
//   vld_out     in   FIFO not empty
//   data_in     in   FIFO data, valid the cycle after read_enb
//   sink_ready  in   downstream can take bytes (gates new reads only)
//   read_enb    out  FIFO read strobe
//   pkt_data    out  captured byte
//   pkt_valid   out  pkt_data valid, one cycle per byte
//   pkt_sop     out  header byte marker
//   pkt_eop     out  parity byte marker
//   hdr_addr    out  header[1:0], held until the next header
//   pkt_len     out  header[7:2], held until the next header
//   pkt_done    out  one-cycle pulse after the eop byte
//   parity_err  out  valid with pkt_done, XOR of all bytes non-zero
//   pkt_abort   out  one-cycle pulse, soft_reset hit a packet in progress
//   busy        out  state != IDLE
//
// state    | meaning
// IDLE     | one-cycle gap after reset / DONE / soft_reset
// HDR_REQ  | waiting to issue the header read
// HDR_WAIT | header byte returning on data_in
// BODY     | issuing payload+parity reads, capturing returning bytes
// DONE     | report pkt_done and parity result
module router_pkt_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       vld_out,
  input  logic [7:0] data_in,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic [1:0] hdr_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, HDR_REQ, HDR_WAIT, BODY, DONE} state_t;

  state_t     state;
  logic [6:0] req_cnt;     // body reads issued
  logic [6:0] rcv_cnt;     // body bytes captured
  logic [6:0] total_len;   // len + 1 (payload plus parity byte)
  logic [7:0] parity_acc;
  logic       rd_inflight; // read_enb was high last cycle, byte on data_in now

  // Reads are suppressed during reset/soft_reset so nothing is pulled from a
  // FIFO that is being flushed.
  always_comb begin
    read_enb = 1'b0;
    if (!reset && !soft_reset && vld_out && sink_ready) begin
      if (state == HDR_REQ)
        read_enb = 1'b1;
      else if (state == BODY && req_cnt < total_len)
        read_enb = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_cnt     <= '0;
      rcv_cnt     <= '0;
      total_len   <= '0;
      parity_acc  <= '0;
      rd_inflight <= 1'b0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_sop     <= 1'b0;
      pkt_eop     <= 1'b0;
      hdr_addr    <= '0;
      pkt_len     <= '0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      pkt_abort   <= 1'b0;
    end else begin
      pkt_valid   <= 1'b0;
      pkt_sop     <= 1'b0;
      pkt_eop     <= 1'b0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      pkt_abort   <= 1'b0;
      rd_inflight <= read_enb;

      if (soft_reset) begin
        // Any byte on data_in this cycle belongs to the flushed FIFO: drop it.
        pkt_abort   <= (state == HDR_WAIT) || (state == BODY) ||
                       (state == DONE) || rd_inflight;
        state       <= IDLE;
        req_cnt     <= '0;
        rcv_cnt     <= '0;
        total_len   <= '0;
        parity_acc  <= '0;
        rd_inflight <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= HDR_REQ;

          HDR_REQ: if (read_enb) state <= HDR_WAIT;

          HDR_WAIT: begin
            hdr_addr   <= data_in[1:0];
            pkt_len    <= data_in[7:2];
            total_len  <= {1'b0, data_in[7:2]} + 7'd1;
            req_cnt    <= '0;
            rcv_cnt    <= '0;
            parity_acc <= data_in;
            pkt_data   <= data_in;
            pkt_valid  <= 1'b1;
            pkt_sop    <= 1'b1;
            state      <= BODY;
          end

          BODY: begin
            if (read_enb)
              req_cnt <= req_cnt + 7'd1;
            if (rd_inflight) begin
              pkt_data   <= data_in;
              pkt_valid  <= 1'b1;
              parity_acc <= parity_acc ^ data_in;
              rcv_cnt    <= rcv_cnt + 7'd1;
              if (rcv_cnt == total_len - 7'd1) begin
                pkt_eop <= 1'b1;
                state   <= DONE;
              end
            end
          end

          DONE: begin
            pkt_done   <= 1'b1;
            parity_err <= (parity_acc != 8'd0);
            parity_acc <= '0;
            state      <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader
//   Directed and randomized packets fed through a queue-based FIFO model;
//   the expected byte stream, framing and parity verdict are derived from
//   the packet format itself.
module tb_router_pkt_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       soft_reset = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       sink_ready = 1'b1;
  logic       read_enb;
  logic [7:0] pkt_data;
  logic       pkt_valid, pkt_sop, pkt_eop;
  logic [1:0] hdr_addr;
  logic [5:0] pkt_len;
  logic       pkt_done, parity_err, pkt_abort, busy;

  router_pkt_reader dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .vld_out(vld_out),
    .data_in(data_in), .sink_ready(sink_ready), .read_enb(read_enb),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .hdr_addr(hdr_addr), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] pkt_q[$];
  logic [7:0] got_q[$];
  logic [1:0] got_fr[$];   // {sop, eop} per captured byte
  int total = 0, bad = 0;
  int done_cnt, abort_cnt, rd_cnt, viol_cnt;
  logic last_perr;
  bit vld_gate = 1'b1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample read_enb before the edge, model FIFO after it,
  // monitor DUT outputs on the falling edge.
  task automatic tick();
    bit rd;
    vld_out = (fifo_q.size() != 0) && vld_gate;
    #1;
    rd = read_enb;
    if (rd) rd_cnt++;
    if (rd && !(vld_out && sink_ready)) viol_cnt++;
    @(posedge clk); #1;
    if (soft_reset) fifo_q.delete();
    else if (rd) data_in = fifo_q.pop_front();
    vld_out = (fifo_q.size() != 0) && vld_gate;
    @(negedge clk);
    if (pkt_valid) begin
      got_q.push_back(pkt_data);
      got_fr.push_back({pkt_sop, pkt_eop});
    end else if (pkt_sop || pkt_eop) viol_cnt++;
    if (pkt_done) begin done_cnt++; last_perr = parity_err; end
    if (pkt_abort) abort_cnt++;
  endtask

  task automatic clear_mon();
    got_q.delete(); got_fr.delete();
    done_cnt = 0; abort_cnt = 0; rd_cnt = 0; viol_cnt = 0; last_perr = 1'bx;
  endtask

  // Random packet with given header; parity optionally corrupted.
  task automatic build(input logic [7:0] hdr, input bit corrupt);
    logic [7:0] x, b;
    pkt_q.delete();
    pkt_q.push_back(hdr);
    x = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom);
      pkt_q.push_back(b);
      x ^= b;
    end
    pkt_q.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // mode 0 plain, 1 vld_out stall of 3 cycles mid-payload,
  // 2 sink_ready toggling, 3 random gating of both.
  task automatic run_pkt(input string name, input int mode);
    logic [7:0] x;
    int n, stall_left, nb;
    bit stalled;
    x = 8'd0;
    foreach (pkt_q[i]) x ^= pkt_q[i];
    nb = pkt_q.size();
    clear_mon();
    foreach (pkt_q[i]) fifo_q.push_back(pkt_q[i]);
    n = 0; stall_left = 0; stalled = 1'b0;
    while (done_cnt == 0 && n < 600) begin
      case (mode)
        1: begin
          if (rd_cnt >= 3 && !stalled) begin stall_left = 3; stalled = 1'b1; end
          vld_gate = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: sink_ready = n[0];
        3: begin
          vld_gate = ($urandom % 4) != 0;
          sink_ready = ($urandom % 3) != 0;
        end
        default: ;
      endcase
      tick();
      n++;
    end
    vld_gate = 1'b1;
    sink_ready = 1'b1;
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " byte_count"}, got_q.size(), nb);
    for (int i = 0; i < nb && i < got_q.size(); i++) begin
      chk({name, " byte"}, got_q[i], pkt_q[i]);
      chk({name, " sop_eop"}, got_fr[i], {i == 0, i == nb - 1});
    end
    chk({name, " parity_err"}, last_perr, x != 8'd0);
    chk({name, " hdr_addr"}, hdr_addr, pkt_q[0][1:0]);
    chk({name, " pkt_len"}, pkt_len, pkt_q[0][7:2]);
    chk({name, " reads"}, rd_cnt, nb);
    chk({name, " read_violations"}, viol_cnt, 0);
    chk({name, " aborts"}, abort_cnt, 0);
  endtask

  initial begin
    int n;
    // reset behaviour
    @(negedge clk); @(negedge clk);
    chk("reset ctl", {read_enb, pkt_valid, pkt_sop, pkt_eop, pkt_done,
                      parity_err, pkt_abort, busy}, 0);
    chk("reset fields", {pkt_data, hdr_addr, pkt_len}, 0);
    reset = 1'b0;
    #1;
    chk("idle busy", busy, 0);
    clear_mon();
    tick();
    chk("hdr_req busy", busy, 1);
    chk("empty no read", read_enb, 0);

    // 1: len3 addr1, good parity
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    run_pkt("t1", 0);
    // 2: same packet, bad parity
    pkt_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    run_pkt("t2", 0);
    // 3: zero-length packet
    pkt_q = '{8'h02, 8'h02};
    run_pkt("t3", 0);
    // 4: vld_out stall mid-payload of len-5 packet
    build(8'h15, 1'b0);
    run_pkt("t4", 1);
    // 5: max length with sink_ready toggling
    build(8'hFF, 1'b0);
    run_pkt("t5", 2);

    // 6: soft_reset after 2nd payload byte
    build(8'h0F, 1'b0);
    clear_mon();
    foreach (pkt_q[i]) fifo_q.push_back(pkt_q[i]);
    n = 0;
    while (got_q.size() < 3 && n < 50) begin tick(); n++; end
    chk("t6 reached payload2", got_q.size(), 3);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    tick(); tick(); tick();
    chk("t6 aborts", abort_cnt, 1);
    chk("t6 no done", done_cnt, 0);
    chk("t6 bytes kept", got_q.size(), 3);
    chk("t6 hdr_addr hold", hdr_addr, 2'd3);
    chk("t6 pkt_len hold", pkt_len, 6'd3);
    build(8'h0D, 1'b0);
    run_pkt("t6 next", 0);

    // randomized packets and gating
    for (int k = 0; k < 8; k++) begin
      build(8'($urandom), ($urandom % 2) == 1);
      run_pkt("rand", (k % 2 == 0) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
